seq_edge_switch_monitor: RTL and testbench

//  Parametrised bus-switching monitor. Samples an NBITS bus on each valid beat and compares it

---
 rtl/switch_mon_pkg.sv | 47 ++++
 rtl/seq_edge_switch_popcount.sv | 21 ++
 rtl/seq_edge_switch_monitor.sv | 114 +++++++++++
 tb/tb_seq_edge_switch_monitor.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/switch_mon_pkg.sv
// Shared types and helpers for the seq_edge_switch_monitor bus-switching watchdog.
package switch_mon_pkg;

  typedef enum logic {
    SWM_ALT_ONLY = 1'b0,
    SWM_ANY_FULL = 1'b1
  } swm_mode_e;

  // Widest bus the alternating-pattern helper can describe.
  localparam int unsigned SWM_MAX_BITS = 256;

  // Bits needed to hold a count in the range 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Alternating pattern 0101.. of nbits, LSB set (0x55 for 8 bits).
  function automatic logic [SWM_MAX_BITS-1:0] alt_mask(input int unsigned nbits);
    logic [SWM_MAX_BITS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < SWM_MAX_BITS; i++) begin
      m[i] = (i < nbits) && (i % 2 == 0);
    end
    return m;
  endfunction

  // Ones in the low nbits positions.
  function automatic logic [SWM_MAX_BITS-1:0] width_mask(input int unsigned nbits);
    logic [SWM_MAX_BITS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < SWM_MAX_BITS; i++) begin
      m[i] = (i < nbits);
    end
    return m;
  endfunction

  // True when the zero-extended value is 0101.. or 1010.. over nbits.
  function automatic logic is_alt_pattern(input logic [SWM_MAX_BITS-1:0] value,
                                          input int unsigned nbits);
    logic [SWM_MAX_BITS-1:0] even_set;
    logic [SWM_MAX_BITS-1:0] odd_set;
    even_set = alt_mask(nbits);
    odd_set  = ~even_set & width_mask(nbits);
    return (value == even_set) || (value == odd_set);
  endfunction

endpackage

// File: rtl/seq_edge_switch_popcount.sv
// Combinational population count of the bus toggle vector.
module seq_edge_switch_popcount
  import switch_mon_pkg::*;
#(
  parameter int unsigned NBITS = 8
) (
  input  logic [NBITS-1:0]             diff,
  output logic [$clog2(NBITS+1)-1:0]   count
);

  localparam int unsigned CW = cnt_width(NBITS);

  always_comb begin
    // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
    count = '0;
    for (int unsigned i = 0; i < NBITS; i++) begin
      count = count + CW'(diff[i]);
    end
  end

endmodule

// File: rtl/seq_edge_switch_monitor.sv
// Bus-switching watchdog: per-beat toggle count, worst-case flag and windowed alarm.
// Optional build macro SWITCH_MON_STICKY_EN makes the alarm hold until clear/reset.
module seq_edge_switch_monitor
  import switch_mon_pkg::*;
#(
  parameter int unsigned NBITS  = 8,
  parameter int unsigned MODE   = 0,
  parameter int unsigned WINDOW = 16,
  parameter int unsigned THRESH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_val,
  input  logic [NBITS-1:0]              in_,
  input  logic                          clear,
  output logic                          max_switching,
  output logic [$clog2(NBITS+1)-1:0]    toggle_count,
  output logic [$clog2(WINDOW+1)-1:0]   window_count,
  output logic                          alarm
);

  localparam int unsigned TCW = cnt_width(NBITS);
  localparam int unsigned WCW = cnt_width(WINDOW);
  localparam int unsigned BCW = cnt_width(WINDOW);
  localparam swm_mode_e   MODE_E = swm_mode_e'(MODE[0]);

  localparam logic [BCW-1:0] LAST_BEAT  = BCW'(WINDOW - 1);
  localparam logic [WCW-1:0] THRESH_CNT = WCW'(THRESH);

  logic [NBITS-1:0] prev;
  logic             prev_ok;
  logic [BCW-1:0]   beat_cnt;

  logic [NBITS-1:0] diff;
  logic [TCW-1:0]   pop;
  logic             qual;
  logic             full_toggle;
  logic             alt_hit;
  logic             last_beat;
  logic [WCW-1:0]   win_sum;
  logic             win_hit;
  logic             alarm_nxt;

  assign diff = in_ ^ prev;

  seq_edge_switch_popcount #(
    .NBITS (NBITS)
  ) u_popcount (
    .diff  (diff),
    .count (pop)
  );

  // Per-beat classification; an unqualified beat has no history to compare against.
  always_comb begin
    qual          = in_val & prev_ok;
    full_toggle   = &diff;
    alt_hit       = is_alt_pattern(SWM_MAX_BITS'(in_), NBITS);
    max_switching = 1'b0;
    toggle_count  = '0;
    if (qual) begin
      toggle_count = pop;
      if (MODE_E == SWM_ANY_FULL) begin
        max_switching = full_toggle;
      end else begin
        max_switching = full_toggle & alt_hit;
      end
    end
  end

  // The event on the closing beat counts toward its own window.
  always_comb begin
    last_beat = in_val && (beat_cnt == LAST_BEAT);
    win_sum   = window_count + WCW'(max_switching);
    win_hit   = last_beat && (win_sum >= THRESH_CNT);
`ifdef SWITCH_MON_STICKY_EN
    alarm_nxt = alarm | win_hit;
`else
    alarm_nxt = win_hit;
`endif
  end

  // Sample history; gaps without in_val hold the last valid sample.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      prev    <= '0;
      prev_ok <= 1'b0;
    end else if (in_val) begin
      prev    <= in_;
      prev_ok <= 1'b1;
    end
  end

  // Window bookkeeping; clear outranks the normal update, including on a closing beat.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      beat_cnt     <= '0;
      window_count <= '0;
      alarm        <= 1'b0;
    end else begin
      alarm <= alarm_nxt;
      if (in_val) begin
        if (last_beat) begin
          beat_cnt     <= '0;
          window_count <= '0;
        end else begin
          beat_cnt     <= beat_cnt + BCW'(1);
          window_count <= win_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_edge_switch_monitor.sv
// Directed self-checking bench for seq_edge_switch_monitor (NBITS=8, WINDOW=4).
module tb_seq_edge_switch_monitor;

`ifdef SWITCH_MON_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       in_val;
  logic [7:0] in_;
  logic       clear;

  // a: MODE0 THRESH2, m: MODE1 THRESH2, t: MODE0 THRESH4
  logic       ms_a, ms_m, ms_t;
  logic [3:0] tc_a, tc_m, tc_t;
  logic [2:0] wc_a, wc_m, wc_t;
  logic       al_a, al_m, al_t;

  int checks = 0;
  int errors = 0;

  seq_edge_switch_monitor #(.NBITS(8), .MODE(0), .WINDOW(4), .THRESH(2)) dut_a (
    .clk(clk), .reset(reset), .in_val(in_val), .in_(in_), .clear(clear),
    .max_switching(ms_a), .toggle_count(tc_a), .window_count(wc_a), .alarm(al_a));

  seq_edge_switch_monitor #(.NBITS(8), .MODE(1), .WINDOW(4), .THRESH(2)) dut_m (
    .clk(clk), .reset(reset), .in_val(in_val), .in_(in_), .clear(clear),
    .max_switching(ms_m), .toggle_count(tc_m), .window_count(wc_m), .alarm(al_m));

  seq_edge_switch_monitor #(.NBITS(8), .MODE(0), .WINDOW(4), .THRESH(4)) dut_t (
    .clk(clk), .reset(reset), .in_val(in_val), .in_(in_), .clear(clear),
    .max_switching(ms_t), .toggle_count(tc_t), .window_count(wc_t), .alarm(al_t));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are read 1 time unit later.
  task automatic step(input logic v, input logic [7:0] d, input logic c);
    @(negedge clk);
    in_val = v;
    in_    = d;
    clear  = c;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    checks++; if (ms_a !== 1'b0) begin errors++; $display("FAIL reset_ms got %0b want 0", ms_a); end
    checks++; if (tc_a !== 4'd0) begin errors++; $display("FAIL reset_tc got %0d want 0", tc_a); end
    checks++; if (wc_a !== 3'd0) begin errors++; $display("FAIL reset_wc got %0d want 0", wc_a); end
    checks++; if (al_a !== 1'b0) begin errors++; $display("FAIL reset_alarm got %0b want 0", al_a); end
  endtask

  task automatic test_alt_stream;
    logic [7:0] d   [4] = '{8'h55, 8'hAA, 8'h55, 8'hAA};
    logic       ems [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] etc [4] = '{4'd0, 4'd8, 4'd8, 4'd8};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, d[i], 1'b0);
      checks++; if (ms_a !== ems[i]) begin errors++; $display("FAIL alt_ms beat%0d got %0b want %0b", i, ms_a, ems[i]); end
      checks++; if (tc_a !== etc[i]) begin errors++; $display("FAIL alt_tc beat%0d got %0d want %0d", i, tc_a, etc[i]); end
      checks++; if (ms_m !== ems[i]) begin errors++; $display("FAIL alt_ms_mode1 beat%0d got %0b want %0b", i, ms_m, ems[i]); end
    end
    step(1'b0, 8'h00, 1'b0);
    checks++; if (al_a !== 1'b1) begin errors++; $display("FAIL alt_alarm got %0b want 1", al_a); end
    checks++; if (wc_a !== 3'd0) begin errors++; $display("FAIL alt_wc_wrap got %0d want 0", wc_a); end
    checks++; if (al_t !== 1'b0) begin errors++; $display("FAIL alt_alarm_t4 got %0b want 0", al_t); end
    step(1'b0, 8'h00, 1'b0);
    checks++; if (al_a !== STICKY) begin errors++; $display("FAIL alt_alarm_hold got %0b want %0b", al_a, STICKY); end
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    checks++; if (al_a !== 1'b0) begin errors++; $display("FAIL alt_alarm_clear got %0b want 0", al_a); end
  endtask

  task automatic test_mode;
    step(1'b1, 8'h00, 1'b0);
    checks++; if (tc_a !== 4'd4) begin errors++; $display("FAIL mode_tc_partial got %0d want 4", tc_a); end
    checks++; if (ms_a !== 1'b0) begin errors++; $display("FAIL mode_ms_partial got %0b want 0", ms_a); end
    step(1'b1, 8'hFF, 1'b0);
    checks++; if (ms_a !== 1'b0) begin errors++; $display("FAIL mode0_full got %0b want 0", ms_a); end
    checks++; if (tc_a !== 4'd8) begin errors++; $display("FAIL mode0_tc got %0d want 8", tc_a); end
    checks++; if (ms_m !== 1'b1) begin errors++; $display("FAIL mode1_full got %0b want 1", ms_m); end
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_gap;
    step(1'b1, 8'h55, 1'b0);
    checks++; if (tc_a !== 4'd4) begin errors++; $display("FAIL gap_tc_first got %0d want 4", tc_a); end
    step(1'b1, 8'hAA, 1'b0);
    checks++; if (ms_a !== 1'b1) begin errors++; $display("FAIL gap_ms_aa got %0b want 1", ms_a); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h55, 1'b0);
      checks++; if (ms_a !== 1'b0) begin errors++; $display("FAIL gap_ms idle%0d got %0b want 0", i, ms_a); end
      checks++; if (tc_a !== 4'd0) begin errors++; $display("FAIL gap_tc idle%0d got %0d want 0", i, tc_a); end
    end
    step(1'b1, 8'h55, 1'b0);
    checks++; if (ms_a !== 1'b1) begin errors++; $display("FAIL gap_ms_resume got %0b want 1", ms_a); end
    checks++; if (tc_a !== 4'd8) begin errors++; $display("FAIL gap_tc_resume got %0d want 8", tc_a); end
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_window_alarm;
    logic [7:0] d   [4] = '{8'h55, 8'hAA, 8'h55, 8'h13};
    logic       ems [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] etc [4] = '{4'd0, 4'd8, 4'd8, 4'd3};
    logic [2:0] ewc [4] = '{3'd0, 3'd0, 3'd1, 3'd2};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, d[i], 1'b0);
      checks++; if (ms_a !== ems[i]) begin errors++; $display("FAIL win_ms beat%0d got %0b want %0b", i, ms_a, ems[i]); end
      checks++; if (tc_a !== etc[i]) begin errors++; $display("FAIL win_tc beat%0d got %0d want %0d", i, tc_a, etc[i]); end
      checks++; if (wc_a !== ewc[i]) begin errors++; $display("FAIL win_wc beat%0d got %0d want %0d", i, wc_a, ewc[i]); end
      checks++; if (al_a !== 1'b0) begin errors++; $display("FAIL win_alarm_early beat%0d got %0b want 0", i, al_a); end
    end
    step(1'b0, 8'h00, 1'b0);
    checks++; if (al_a !== 1'b1) begin errors++; $display("FAIL win_alarm got %0b want 1", al_a); end
    checks++; if (wc_a !== 3'd0) begin errors++; $display("FAIL win_wc_wrap got %0d want 0", wc_a); end
    checks++; if (al_t !== 1'b0) begin errors++; $display("FAIL win_alarm_t4 got %0b want 0", al_t); end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 8'h00, 1'b0);
      checks++; if (al_a !== STICKY) begin errors++; $display("FAIL win_alarm_after%0d got %0b want %0b", i, al_a, STICKY); end
    end
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    checks++; if (al_a !== 1'b0) begin errors++; $display("FAIL win_alarm_clear got %0b want 0", al_a); end
  endtask

  task automatic test_threshold;
    logic [7:0] d1   [4] = '{8'h55, 8'hAA, 8'h13, 8'h55};
    logic [2:0] ewc1 [4] = '{3'd0, 3'd0, 3'd1, 3'd1};
    logic [7:0] d2   [4] = '{8'hAA, 8'h55, 8'hAA, 8'h55};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, d1[i], 1'b0);
      checks++; if (wc_a !== ewc1[i]) begin errors++; $display("FAIL thr_wc1 beat%0d got %0d want %0d", i, wc_a, ewc1[i]); end
    end
    step(1'b0, 8'h00, 1'b0);
    checks++; if (al_a !== 1'b0) begin errors++; $display("FAIL thr_alarm_one got %0b want 0", al_a); end
    checks++; if (wc_a !== 3'd0) begin errors++; $display("FAIL thr_wc_wrap1 got %0d want 0", wc_a); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, d2[i], 1'b0);
      checks++; if (ms_t !== 1'b1) begin errors++; $display("FAIL thr_ms beat%0d got %0b want 1", i, ms_t); end
      checks++; if (wc_t !== 3'(i)) begin errors++; $display("FAIL thr_wc_t4 beat%0d got %0d want %0d", i, wc_t, i); end
    end
    step(1'b0, 8'h00, 1'b0);
    checks++; if (al_t !== 1'b1) begin errors++; $display("FAIL thr_alarm_t4 got %0b want 1", al_t); end
    checks++; if (wc_t !== 3'd0) begin errors++; $display("FAIL thr_wc_wrap_t4 got %0d want 0", wc_t); end
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset_mid;
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    checks++; if (wc_a !== 3'd2) begin errors++; $display("FAIL mid_wc_pre got %0d want 2", wc_a); end
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    checks++; if (ms_a !== 1'b0) begin errors++; $display("FAIL mid_ms got %0b want 0", ms_a); end
    checks++; if (tc_a !== 4'd0) begin errors++; $display("FAIL mid_tc got %0d want 0", tc_a); end
    checks++; if (wc_a !== 3'd0) begin errors++; $display("FAIL mid_wc got %0d want 0", wc_a); end
    checks++; if (al_a !== 1'b0) begin errors++; $display("FAIL mid_alarm got %0b want 0", al_a); end
    step(1'b1, 8'h55, 1'b0);
    checks++; if (ms_a !== 1'b0) begin errors++; $display("FAIL mid_first_ms got %0b want 0", ms_a); end
    checks++; if (tc_a !== 4'd0) begin errors++; $display("FAIL mid_first_tc got %0d want 0", tc_a); end
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'hAA, 1'b1);
    checks++; if (ms_a !== 1'b1) begin errors++; $display("FAIL clr_last_ms got %0b want 1", ms_a); end
    checks++; if (wc_a !== 3'd2) begin errors++; $display("FAIL clr_last_wc_pre got %0d want 2", wc_a); end
    step(1'b0, 8'h00, 1'b0);
    checks++; if (al_a !== 1'b0) begin errors++; $display("FAIL clr_last_alarm got %0b want 0", al_a); end
    checks++; if (wc_a !== 3'd0) begin errors++; $display("FAIL clr_last_wc got %0d want 0", wc_a); end
  endtask

  initial begin
    reset  = 1'b1;
    in_val = 1'b0;
    in_    = 8'h00;
    clear  = 1'b0;
    test_reset();
    test_alt_stream();
    test_mode();
    test_gap();
    test_window_alarm();
    test_threshold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "bench did not complete");
  end

endmodule
